// File: rtl/sram_ram16_responder.sv
// sram_ram16_responder: pin-level 16-bit SRAM stand-in with byte-masked writes and a programmable read latency.
// Optional protocol checker enabled by defining SRAM_RESP_CHECK_EN. Rev 1.0
`default_nettype none

module sram_ram16_responder #(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_ram,
  input  logic [1:0]        byteena_ram,
  input  logic [15:0]       data_ram,
  input  logic              data_oe_tri,
  input  logic              wren_ram,
  input  logic              ce_ram,
  input  logic              oe_ram,
  output logic [15:0]       q_ram,
  output logic              rd_valid,
  output logic [2:0]        err_flags
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  logic [15:0]       mem [DEPTH];
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_hit;
  logic              rd_req;

  assign wr_hit = ce_ram & wren_ram & data_oe_tri;
  assign rd_req = ce_ram & oe_ram & ~wren_ram;

  // Array has no reset; rst only suppresses a write on the same edge.
  always_ff @(posedge clock) begin
    if (!rst && wr_hit) begin
      if (byteena_ram[0]) mem[address_ram][7:0]  <= data_ram[7:0];
      if (byteena_ram[1]) mem[address_ram][15:8] <= data_ram[15:8];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      addr_q   <= '0;
      q_ram    <= 16'h0000;
      rd_valid <= 1'b0;
    end else if (!ce_ram || wren_ram) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      q_ram    <= 16'h0000;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            addr_q <= address_ram;
            if (RD_LAT == 1) begin
              q_ram    <= mem[address_ram];
              rd_valid <= 1'b1;
              state    <= S_DRIVE;
            end else begin
              cnt   <= LAT_M1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!rd_req) begin
            state <= S_IDLE;
            q_ram <= 16'h0000;
          end else if (address_ram != addr_q) begin
            addr_q <= address_ram;
            cnt    <= LAT_M1;
          end else if (cnt == 4'd1) begin
            q_ram    <= mem[addr_q];
            rd_valid <= 1'b1;
            state    <= S_DRIVE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DRIVE: begin
          if (!rd_req) begin
            state    <= S_IDLE;
            q_ram    <= 16'h0000;
            rd_valid <= 1'b0;
          end else if (address_ram != addr_q) begin
            // New address restarts the latency count as if from idle.
            addr_q <= address_ram;
            if (RD_LAT == 1) begin
              q_ram <= mem[address_ram];
            end else begin
              q_ram    <= 16'h0000;
              rd_valid <= 1'b0;
              cnt      <= LAT_M1;
              state    <= S_WAIT;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          q_ram    <= 16'h0000;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_RESP_CHECK_EN
  logic [2:0] err_q;

  // Sticky flags: contention, undriven write data, bus drive contention.
  always_ff @(posedge clock) begin
    if (rst) begin
      err_q <= 3'b000;
    end else begin
      err_q <= err_q | {ce_ram & oe_ram & data_oe_tri,
                        ce_ram & wren_ram & ~data_oe_tri,
                        ce_ram & wren_ram & oe_ram};
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_ram16_responder.sv
// Scoreboard bench for sram_ram16_responder: directed cases plus randomized traffic against a read-run model.
`default_nettype none

module tb_sram_ram16_responder;

  localparam int AW  = 9;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] address_ram = '0;
  logic [1:0]    byteena_ram = 2'b00;
  logic [15:0]   data_ram = 16'h0000;
  logic          data_oe_tri = 1'b0;
  logic          wren_ram = 1'b0;
  logic          ce_ram = 1'b0;
  logic          oe_ram = 1'b0;
  logic [15:0]   q_ram;
  logic          rd_valid;
  logic [2:0]    err_flags;

  sram_ram16_responder #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clock(clock), .rst(rst), .address_ram(address_ram), .byteena_ram(byteena_ram),
    .data_ram(data_ram), .data_oe_tri(data_oe_tri), .wren_ram(wren_ram),
    .ce_ram(ce_ram), .oe_ram(oe_ram), .q_ram(q_ram), .rd_valid(rd_valid),
    .err_flags(err_flags)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] q;
    logic        v;
    logic [2:0]  e;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  bit          done = 0;

  // Reference model: a word array plus the length of the current uninterrupted read run.
  logic [15:0] mmem [1 << AW];
  int          run_len = 0;
  int          run_addr = 0;
  logic [2:0]  mflags = 3'b000;

  task automatic step(input logic r, input logic [AW-1:0] a, input logic [1:0] be,
                      input logic [15:0] d, input logic doe, input logic we,
                      input logic ce, input logic oe);
    exp_t x;
    rst = r; address_ram = a; byteena_ram = be; data_ram = d;
    data_oe_tri = doe; wren_ram = we; ce_ram = ce; oe_ram = oe;
    @(posedge clock);
    if (r) begin
      run_len = 0;
      mflags  = 3'b000;
    end else begin
`ifdef SRAM_RESP_CHECK_EN
      mflags = mflags | {ce & oe & doe, ce & we & ~doe, ce & we & oe};
`endif
      if (ce && we && doe) begin
        if (be[0]) mmem[a][7:0]  = d[7:0];
        if (be[1]) mmem[a][15:8] = d[15:8];
      end
      if (ce && oe && !we) begin
        if (run_len > 0 && int'(a) == run_addr) begin
          if (run_len < 100) run_len++;
        end else begin
          run_len  = 1;
          run_addr = int'(a);
        end
      end else begin
        run_len = 0;
      end
    end
    x.v = (run_len >= LAT);
    x.q = x.v ? mmem[run_addr] : 16'h0000;
    x.e = mflags;
    sb.push_back(x);
    @(negedge clock);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [1:0] be, input logic [15:0] d);
    step(1'b0, a, be, d, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) step(1'b0, a, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the outputs are a response; compare against the oldest expectation.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (q_ram !== x.q || rd_valid !== x.v || err_flags !== x.e) begin
          failures++;
          $display("FAIL resp t=%0t q_ram=%h rd_valid=%b err_flags=%b expected q=%h valid=%b err=%b",
                   $time, q_ram, rd_valid, err_flags, x.q, x.v, x.e);
        end
      end
    end
  end

  initial begin : driver
    @(negedge clock);
    step(1'b1, '0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, '0, 2'b11, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < (1 << AW); i++) wr(AW'(i), 2'b11, 16'($urandom));
    idle(1);

    wr(9'h010, 2'b11, 16'hA55A);
    rd(9'h010, 3);
    wr(9'h010, 2'b10, 16'h3C00);
    rd(9'h010, 3);
    wr(9'h010, 2'b01, 16'h00FF);
    rd(9'h010, 3);
    idle(1);

    rd(9'h010, 1);
    rd(9'h011, 3);
    rd(9'h010, 3);
    step(1'b0, 9'h010, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    step(1'b0, 9'h030, 2'b11, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b1);
    rd(9'h030, 3);
    wr(9'h020, 2'b11, 16'h1234);
    step(1'b0, 9'h020, 2'b11, 16'hDEAD, 1'b0, 1'b1, 1'b1, 1'b0);
    rd(9'h020, 3);

    rd(9'h010, 1);
    step(1'b1, 9'h010, 2'b11, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
    rd(9'h010, 3);
    rd(9'h020, 3);
    step(1'b1, 9'h020, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    rd(9'h020, 3);

    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      logic          we;
      a  = ($urandom_range(0, 3) != 0) ? address_ram : AW'($urandom_range(0, 15));
      we = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 63) == 0), a, 2'($urandom), 16'($urandom),
           we ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0),
           we, ($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0));
    end
    idle(2);
    done = 1;
  end

  initial begin : finisher
    int guard;
    guard = 0;
    while (!done && guard < 20000) begin
      @(posedge clock);
      guard++;
    end
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (!done || sb.size() != 0) begin
      failures++;
      $display("FAIL drain done=%0d pending=%0d required done=1 pending=0", done, sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
